inst_fetch_port: RTL

//   Memory-side responder for the PC register. Takes the fetch address (pc) and the MEM-stage data

---
 rtl/inst_fetch_port.sv | 116 +++++++++++
 1 files changed

// File: rtl/inst_fetch_port.sv
// inst_fetch_port: time-shares one asynchronous SRAM between instruction fetch and MEM-stage data access
module inst_fetch_port #(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [15:0]        if_addr,
  output logic [15:0]        if_inst,
  output logic [15:0]        if_inst_addr,
  output logic               if_valid,
  output logic               pc_keep,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [15:0]        mem_addr,
  input  logic [15:0]        mem_wdata,
  output logic [15:0]        mem_rdata,
  output logic               mem_done,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dout,
  input  logic [15:0]        sram_din,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);
  localparam int CW = $clog2(WAIT_CYCLES + 2);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);
  typedef enum logic [2:0] {IDLE, FETCH, DREAD, DWRITE, WHOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_dout_q, sram_dout_d;
  logic [15:0] if_inst_q, if_inst_d;
  logic [15:0] if_inst_addr_q, if_inst_addr_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;
  logic if_valid_q, if_valid_d;
  logic mem_done_q, mem_done_d;
  logic ce_n_q, ce_n_d;
  logic oe_n_q, oe_n_d;
  logic we_n_q, we_n_d;
  logic dq_oe_q, dq_oe_d;
  logic strobe, last, fetch_end, read_end, start, mem_go, if_go;
  // Next-state: arbitrate in IDLE and on each access's completing edge; a finishing data access
  // ignores mem_req so the requester gets its mem_done cycle to drop it without a repeat access.
  always_comb begin
    strobe         = state_q inside {FETCH, DREAD, DWRITE};
    last           = cnt_q == LAST;
    fetch_end      = state_q == FETCH && last;
    read_end       = state_q == DREAD && last;
    start          = state_q == IDLE || fetch_end || read_end || state_q == WHOLD;
    mem_go         = mem_req && (state_q == IDLE || fetch_end);
    if_go          = start && if_req && !mem_go;
    state_d        = mem_go ? (mem_we ? DWRITE : DREAD) :
                     if_go ? FETCH :
                     start ? IDLE :
                     (state_q == DWRITE && last) ? WHOLD : state_q;
    cnt_d          = (strobe && !last) ? cnt_q + 1'b1 : '0;
    sram_addr_d    = mem_go ? SRAM_AW'(mem_addr) : if_go ? SRAM_AW'(if_addr) : sram_addr_q;
    sram_dout_d    = (mem_go && mem_we) ? mem_wdata : sram_dout_q;
    ce_n_d         = state_d == IDLE;
    oe_n_d         = !(state_d inside {FETCH, DREAD});
    we_n_d         = state_d != DWRITE;
    dq_oe_d        = state_d inside {DWRITE, WHOLD};
    if_inst_d      = fetch_end ? sram_din : if_inst_q;
    if_inst_addr_d = fetch_end ? sram_addr_q[15:0] : if_inst_addr_q;
    if_valid_d     = fetch_end && sram_addr_q == SRAM_AW'(if_addr);
    mem_rdata_d    = read_end ? sram_din : mem_rdata_q;
    mem_done_d     = read_end || state_q == WHOLD;
  end
  // All state and every SRAM pin are registered; reset parks the pins inactive at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sram_addr_q    <= '0;
      sram_dout_q    <= '0;
      if_inst_q      <= '0;
      if_inst_addr_q <= '0;
      mem_rdata_q    <= '0;
      if_valid_q     <= 1'b0;
      mem_done_q     <= 1'b0;
      ce_n_q         <= 1'b1;
      oe_n_q         <= 1'b1;
      we_n_q         <= 1'b1;
      dq_oe_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sram_addr_q    <= sram_addr_d;
      sram_dout_q    <= sram_dout_d;
      if_inst_q      <= if_inst_d;
      if_inst_addr_q <= if_inst_addr_d;
      mem_rdata_q    <= mem_rdata_d;
      if_valid_q     <= if_valid_d;
      mem_done_q     <= mem_done_d;
      ce_n_q         <= ce_n_d;
      oe_n_q         <= oe_n_d;
      we_n_q         <= we_n_d;
      dq_oe_q        <= dq_oe_d;
    end
  end
  assign pc_keep      = if_req & ~if_valid_q;
  assign if_inst      = if_inst_q;
  assign if_inst_addr = if_inst_addr_q;
  assign if_valid     = if_valid_q;
  assign mem_rdata    = mem_rdata_q;
  assign mem_done     = mem_done_q;
  assign sram_addr    = sram_addr_q;
  assign sram_dout    = sram_dout_q;
  assign sram_dq_oe   = dq_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
endmodule
